// File: rtl/imem_loadable.sv
// Loadable instruction memory: a program is streamed in over a valid/ready
// handshake, then fetched by word index with a one-cycle registered read.
module imem_loadable #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    input  logic                     fetch_req,
    input  logic [31:0]              PC,
    output logic [DATA_W-1:0]        Instruction,
    output logic                     instr_valid,
    output logic                     fetch_oob,
    output logic [$clog2(DEPTH):0]   prog_len,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [LW-1:0]       wr_ptr;
    logic [LW-1:0]       len_q;
    logic                accept;
    logic                load_begin;
    logic                fetch_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // ld_start is only honoured outside LOADING, so a load can never restart itself.
    always_comb begin
        state_d    = state_q;
        ld_ready   = 1'b0;
        accept     = 1'b0;
        load_begin = 1'b0;
        case (state_q)
            EMPTY: begin
                if (ld_start) begin
                    state_d    = LOADING;
                    load_begin = 1'b1;
                end
            end
            LOADING: begin
                ld_ready = 1'b1;
                accept   = ld_valid;
                if (accept && (ld_last || wr_ptr == LW'(DEPTH - 1)))
                    state_d = READY;
            end
            READY: begin
                if (ld_start) begin
                    state_d    = LOADING;
                    load_begin = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            len_q  <= '0;
        end else if (load_begin) begin
            wr_ptr <= '0;
            len_q  <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + LW'(1);
            len_q  <= len_q + LW'(1);
        end
    end

    // Storage has no reset so it can map onto block RAM; stale words stay unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && accept)
            mem[wr_ptr[AW-1:0]] <= ld_data;
    end

    // Full 32-bit compare against the loaded length, so out-of-range PCs never alias.
    assign fetch_ok = (state_q == READY) && (PC < 32'(len_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_oob   <= 1'b0;
        end else begin
            instr_valid <= fetch_req;
            if (fetch_req) begin
                Instruction <= fetch_ok ? mem[PC[AW-1:0]] : NOP_WORD;
                fetch_oob   <= !fetch_ok;
            end
        end
    end

    assign prog_len = len_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: random load data and fetch patterns
// compared against an array-based model of the load/fetch rules.
module tb_imem_loadable;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] NOP    = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_start, ld_valid, ld_ready, ld_last, fetch_req;
    logic [DATA_W-1:0] ld_data;
    logic [31:0]       PC;
    logic [DATA_W-1:0] Instruction;
    logic              instr_valid, fetch_oob;
    logic [6:0]        prog_len;
    logic [1:0]        state_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: state as 0/1/2, loaded length, and memory image.
    int          m_state;
    int          m_len;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_oob;

    imem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .fetch_req(fetch_req), .PC(PC), .Instruction(Instruction),
        .instr_valid(instr_valid), .fetch_oob(fetch_oob),
        .prog_len(prog_len), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic step();
        if (!rst_n) begin
            m_state = 0; m_len = 0;
            exp_instr = NOP; exp_valid = 1'b0; exp_oob = 1'b0;
        end else begin
            exp_valid = fetch_req;
            if (fetch_req) begin
                if (m_state == 2 && PC < 32'(m_len)) begin
                    exp_instr = m_mem[PC]; exp_oob = 1'b0;
                end else begin
                    exp_instr = NOP; exp_oob = 1'b1;
                end
            end
            if (m_state == 1) begin
                if (ld_valid) begin
                    m_mem[m_len] = ld_data;
                    m_len++;
                    if (ld_last || m_len == DEPTH) m_state = 2;
                end
            end else if (ld_start) begin
                m_state = 1; m_len = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        ld_start = 0; ld_valid = 0; ld_last = 0; fetch_req = 0; ld_data = '0; PC = '0;
    endtask

    task automatic load_words(input int n, input bit mark_last);
        ld_start = 1; step(); ld_start = 0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1; ld_data = $urandom; ld_last = mark_last && (i == n - 1);
            step();
        end
        idle_inputs();
    endtask

    task automatic fetch_once(input logic [31:0] pc);
        fetch_req = 1; PC = pc; step(); fetch_req = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); step(); step();
        n_checks++; if (state_o !== 2'd0) $display("[TB] FAIL reset_state got %0d want 0", state_o); else n_pass++;
        n_checks++; if (prog_len !== 7'd0) $display("[TB] FAIL reset_len got %0d want 0", prog_len); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", ld_ready); else n_pass++;
        n_checks++; if (Instruction !== NOP) $display("[TB] FAIL reset_instr got %h want %h", Instruction, NOP); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0 || fetch_oob !== 1'b0)
            $display("[TB] FAIL reset_flags got v=%b o=%b want 0 0", instr_valid, fetch_oob); else n_pass++;
        rst_n = 1; step();
    endtask

    task automatic test_basic_load();
        int pcs[3] = '{0, 6, 22};
        load_words(23, 1);
        n_checks++; if (state_o !== 2'd2) $display("[TB] FAIL basic_state got %0d want 2", state_o); else n_pass++;
        n_checks++; if (prog_len !== 7'd23) $display("[TB] FAIL basic_len got %0d want 23", prog_len); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL basic_ready got %b want 0", ld_ready); else n_pass++;
        foreach (pcs[k]) begin
            fetch_once(pcs[k]);
            n_checks++;
            if (Instruction !== exp_instr || instr_valid !== 1'b1 || fetch_oob !== 1'b0)
                $display("[TB] FAIL basic_fetch pc=%0d got %h v=%b o=%b want %h v=1 o=0",
                         pcs[k], Instruction, instr_valid, fetch_oob, exp_instr);
            else n_pass++;
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b0 || Instruction !== exp_instr)
            $display("[TB] FAIL basic_hold got %h v=%b want %h v=0", Instruction, instr_valid, exp_instr);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] pcs[4] = '{32'd23, 32'd64, 32'h8000_0000, 32'd87};
        foreach (pcs[k]) begin
            fetch_once(pcs[k]);
            n_checks++;
            if (Instruction !== NOP || instr_valid !== 1'b1 || fetch_oob !== 1'b1)
                $display("[TB] FAIL oob_fetch pc=%h got %h v=%b o=%b want %h v=1 o=1",
                         pcs[k], Instruction, instr_valid, fetch_oob, NOP);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        load_words(DEPTH, 0);
        n_checks++; if (state_o !== 2'd2) $display("[TB] FAIL fill_state got %0d want 2", state_o); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL fill_ready got %b want 0", ld_ready); else n_pass++;
        n_checks++; if (prog_len !== 7'(DEPTH)) $display("[TB] FAIL fill_len got %0d want %0d", prog_len, DEPTH); else n_pass++;
        ld_valid = 1; ld_data = ~m_mem[0]; step(); idle_inputs();
        n_checks++; if (prog_len !== 7'(DEPTH)) $display("[TB] FAIL fill_extra_len got %0d want %0d", prog_len, DEPTH); else n_pass++;
        for (int p = 0; p < DEPTH; p += 21) begin
            fetch_once(p);
            n_checks++;
            if (Instruction !== exp_instr || fetch_oob !== 1'b0)
                $display("[TB] FAIL fill_fetch pc=%0d got %h o=%b want %h o=0", p, Instruction, fetch_oob, exp_instr);
            else n_pass++;
        end
        fetch_once(DEPTH - 1);
        n_checks++;
        if (Instruction !== exp_instr) $display("[TB] FAIL fill_last got %h want %h", Instruction, exp_instr); else n_pass++;
    endtask

    task automatic test_throttled();
        int cnt = 0;
        ld_start = 1; step(); ld_start = 0;
        for (int i = 0; cnt < 10 && i < 60; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = $urandom;
            ld_last  = (cnt == 9);
            ld_start = (i == 7);
            n_checks++;
            if (ld_ready !== (m_state == 1)) $display("[TB] FAIL thr_ready cyc=%0d got %b want %b", i, ld_ready, m_state == 1);
            else n_pass++;
            if (ld_valid && m_state == 1) cnt++;
            step();
        end
        idle_inputs();
        n_checks++; if (prog_len !== 7'd10 || state_o !== 2'd2)
            $display("[TB] FAIL thr_done got len=%0d st=%0d want len=10 st=2", prog_len, state_o); else n_pass++;
        for (int p = 0; p < 10; p++) begin
            fetch_once(p);
            n_checks++;
            if (Instruction !== exp_instr || fetch_oob !== 1'b0)
                $display("[TB] FAIL thr_fetch pc=%0d got %h o=%b want %h o=0", p, Instruction, fetch_oob, exp_instr);
            else n_pass++;
        end
    endtask

    task automatic test_reset_during_load();
        ld_start = 1; step(); ld_start = 0;
        for (int i = 0; i < 5; i++) begin ld_valid = 1; ld_data = $urandom; step(); end
        rst_n = 0; ld_data = $urandom; fetch_req = 1; PC = 0; step();
        rst_n = 1; fetch_req = 0; ld_data = $urandom; step();
        idle_inputs();
        n_checks++; if (state_o !== 2'd0 || prog_len !== 7'd0)
            $display("[TB] FAIL rdl_state got st=%0d len=%0d want st=0 len=0", state_o, prog_len); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL rdl_ready got %b want 0", ld_ready); else n_pass++;
        fetch_once(0);
        n_checks++;
        if (Instruction !== NOP || fetch_oob !== 1'b1 || instr_valid !== 1'b1)
            $display("[TB] FAIL rdl_fetch got %h v=%b o=%b want %h v=1 o=1", Instruction, instr_valid, fetch_oob, NOP);
        else n_pass++;
    endtask

    task automatic test_reload();
        load_words(23, 1);
        load_words(12, 1);
        n_checks++; if (prog_len !== 7'd12) $display("[TB] FAIL reload_len got %0d want 12", prog_len); else n_pass++;
        fetch_once(15);
        n_checks++;
        if (Instruction !== NOP || fetch_oob !== 1'b1)
            $display("[TB] FAIL reload_stale got %h o=%b want %h o=1", Instruction, fetch_oob, NOP);
        else n_pass++;
        fetch_once(11);
        n_checks++;
        if (Instruction !== m_mem[11] || fetch_oob !== 1'b0)
            $display("[TB] FAIL reload_new got %h o=%b want %h o=0", Instruction, fetch_oob, m_mem[11]);
        else n_pass++;
    endtask

    task automatic test_fetch_on_last();
        ld_start = 1; step(); ld_start = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = $urandom; ld_last = (i == 2);
            fetch_req = (i == 2); PC = 0;
            step();
        end
        idle_inputs();
        n_checks++;
        if (Instruction !== NOP || fetch_oob !== 1'b1 || instr_valid !== 1'b1)
            $display("[TB] FAIL coincide got %h v=%b o=%b want %h v=1 o=1", Instruction, instr_valid, fetch_oob, NOP);
        else n_pass++;
        fetch_once(0);
        n_checks++;
        if (Instruction !== m_mem[0] || fetch_oob !== 1'b0)
            $display("[TB] FAIL coincide_next got %h o=%b want %h o=0", Instruction, fetch_oob, m_mem[0]);
        else n_pass++;
    endtask

    task automatic test_random_fetch();
        for (int i = 0; i < 40; i++) begin
            fetch_req = $urandom_range(0, 1);
            PC = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, m_len + 4));
            step();
            n_checks++;
            if (instr_valid !== exp_valid || Instruction !== exp_instr || fetch_oob !== exp_oob)
                $display("[TB] FAIL rand_fetch it=%0d got %h v=%b o=%b want %h v=%b o=%b",
                         i, Instruction, instr_valid, fetch_oob, exp_instr, exp_valid, exp_oob);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_basic_load();
        test_out_of_range();
        test_fill();
        test_throttled();
        test_reset_during_load();
        test_reload();
        test_fetch_on_last();
        test_random_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of instruction words (power of two, 2..4096).
REQ-003 SHALL have parameter NOP_WORD, default 0, value returned for any invalid fetch.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port ld_start  input  1  one-cycle pulse that begins a program load.
REQ-007 SHALL have port ld_valid  input  1  the ld_data word is offered.
REQ-008 SHALL have port ld_ready  output  1  the block accepts a load word this cycle.
REQ-009 SHALL have port ld_data  input  DATA_W  instruction word to store.
REQ-010 SHALL have port ld_last  input  1  marks the final word of the program.
REQ-011 SHALL have port fetch_req  input  1  fetch request.
REQ-012 SHALL have port PC  input  32  word index of the instruction to fetch (not a byte address).
REQ-013 SHALL have port Instruction  output  DATA_W  registered fetch result.
REQ-014 SHALL have port instr_valid  output  1  Instruction is valid this cycle.
REQ-015 SHALL have port fetch_oob  output  1  the last fetch returned NOP_WORD because it was invalid.
REQ-016 SHALL have port prog_len  output  clog2(DEPTH)+1  number of words loaded.
REQ-017 SHALL have port state_o  output  2  state: 0=EMPTY, 1=LOADING, 2=READY.

Function
REQ-018 SHALL implement states EMPTY, LOADING and READY.
REQ-019 SHALL make these transitions:
- EMPTY->LOADING on ld_start.
- READY->LOADING on ld_start.
- LOADING->READY on acceptance of the ld_last word, or on acceptance of the DEPTH-th word.
REQ-020 SHALL clear the write pointer and prog_len to 0 on entry to LOADING.
REQ-021 SHALL drive ld_ready=1 only in LOADING.
REQ-022 SHALL accept a word only when ld_valid and ld_ready are both 1 in the same cycle.
REQ-023 SHALL, on each accepted word, write it at the write pointer, then increment the write pointer and prog_len.
REQ-024 SHALL ignore ld_valid when ld_ready is 0: no write and no counter change.
REQ-025 SHALL ignore ld_start while in LOADING: no restart.
REQ-026 SHALL give fetch a latency of exactly 1 cycle: fetch_req=1 at edge N produces Instruction, instr_valid=1 and fetch_oob after edge N.
REQ-027 SHALL hold Instruction at its last value and drive instr_valid=0 in any cycle without a fetch.
REQ-028 SHALL treat a fetch as valid only when state is READY and PC < prog_len; it then returns mem[PC] with fetch_oob=0.
REQ-029 SHALL treat any other fetch as invalid (EMPTY, LOADING, or PC >= prog_len, including PC >= DEPTH and PC upper bits set); it returns NOP_WORD with instr_valid=1 and fetch_oob=1.
REQ-030 SHALL compare the full 32-bit PC and SHALL NOT wrap addresses modulo DEPTH.
REQ-031 SHALL, when a fetch and the final load word coincide in the same cycle, evaluate the fetch against the pre-edge state, so the fetch returns NOP_WORD.
REQ-032 SHALL not clear memory contents on reload; words beyond the new prog_len are unreachable.

Reset
REQ-033 SHALL, while rst_n=0 at a clock edge, set:
- state to EMPTY;
- prog_len and the write pointer to 0;
- Instruction to NOP_WORD;
- instr_valid, fetch_oob and ld_ready to 0.
REQ-034 SHALL leave memory contents unspecified after reset; they are unreachable until a new load completes.
REQ-035 SHALL, on reset during LOADING, abandon the load, and SHALL ignore any words offered on the following cycle.
REQ-036 SHALL give reset priority over ld_start, load acceptance and fetch in the same cycle.

Verification
REQ-037 SHALL cover basic load and fetch:
- Stimulus: load 23 words with ld_last on the 23rd, then fetch PC=0, 6, 22.
- Required: state READY, prog_len=23; words returned 1 cycle later with instr_valid=1, fetch_oob=0.
REQ-038 SHALL cover out-of-range fetches:
- Stimulus: after the 23-word load, fetch PC=23, PC=DEPTH and PC=0x80000000.
- Required: Instruction=NOP_WORD, instr_valid=1, fetch_oob=1 for each.
REQ-039 SHALL cover a load that fills the memory:
- Stimulus: load DEPTH words with ld_last never set.
- Required: transition to READY after the DEPTH-th word, ld_ready=0, prog_len=DEPTH.
- Stimulus: an extra ld_valid.
- Required: no write.
REQ-040 SHALL cover a throttled load:
- Stimulus: ld_valid toggled every other cycle, and ld_start pulsed mid-load.
- Required: only handshaken words stored, in order; the mid-load ld_start is ignored.
REQ-041 SHALL cover reset during a load:
- Stimulus: rst_n=0 after 5 accepted words.
- Required: EMPTY, prog_len=0; a fetch of PC=0 returns NOP_WORD with fetch_oob=1.
REQ-042 SHALL cover a reload:
- Stimulus: load 23 words, then load 12 words, then fetch PC=15.
- Required: NOP_WORD with fetch_oob=1; fetch PC=11 returns the new word 11.
